pipeline_hazard_ctrl: RTL and testbench



---
 rtl/pipeline_hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: destination-tag scoreboard, operand
// forwarding selects, load-use stall, taken-branch flush and post-reset NOP warm-up.
module pipeline_hazard_ctrl #(
  parameter int WARMUP_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             R,
  input  logic [3:0]       id_rn,
  input  logic [3:0]       id_rm,
  input  logic [3:0]       id_rs,
  input  logic             id_rn_used,
  input  logic             id_rm_used,
  input  logic             id_rs_used,
  input  logic [3:0]       id_rd,
  input  logic             id_rf_enable,
  input  logic             id_load_instr,
  input  logic             branch_taken,
  output logic             pc_le,
  output logic             ifid_le,
  output logic             ifid_flush,
  output logic             nop_sel,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       fwd_c,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYCLES - 1);

  typedef enum logic [1:0] {WARMUP, RUN, STALL, FLUSH} state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] rd;
    logic       is_load;
  } sb_entry_t;

  state_t          state_reg, state_next;
  logic [WW-1:0]   warm_cnt_reg;
  sb_entry_t       ex_reg, mem_reg, wb_reg;
  sb_entry_t       id_entry;

  logic [2:0][3:0] src;
  logic [2:0]      src_used;
  logic [2:0][1:0] fwd_sel;
  logic [2:0]      lu_hit;
  logic            lu;

  assign src      = {id_rs, id_rm, id_rn};
  assign src_used = {id_rs_used, id_rm_used, id_rn_used};

  // r15 is the PC, never a forwarded GPR; a loaded EX result cannot be forwarded yet.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_src
      logic live, ex_hit, mem_hit, wb_hit;
      assign live    = src_used[gi] && (src[gi] != 4'd15);
      assign ex_hit  = live && ex_reg.valid  && (ex_reg.rd  == src[gi]);
      assign mem_hit = live && mem_reg.valid && (mem_reg.rd == src[gi]);
      assign wb_hit  = live && wb_reg.valid  && (wb_reg.rd  == src[gi]);
      assign lu_hit[gi]  = ex_hit && ex_reg.is_load;
      assign fwd_sel[gi] = (ex_hit && !ex_reg.is_load) ? 2'b01 :
                           mem_hit                     ? 2'b10 :
                           wb_hit                      ? 2'b11 : 2'b00;
    end
  endgenerate

  assign lu    = |lu_hit;
  assign fwd_a = fwd_sel[0];
  assign fwd_b = fwd_sel[1];
  assign fwd_c = fwd_sel[2];

  // Outputs respond in the same cycle as the hazard; a stall takes priority over a branch.
  always_comb begin
    pc_le      = 1'b0;
    ifid_le    = 1'b0;
    ifid_flush = 1'b0;
    nop_sel    = 1'b1;
    state_next = state_reg;
    case (state_reg)
      WARMUP: begin
        if (warm_cnt_reg == WARM_LAST) state_next = RUN;
      end
      default: begin
        if (lu) begin
          state_next = STALL;
        end else begin
          pc_le   = 1'b1;
          ifid_le = 1'b1;
          nop_sel = 1'b0;
          if (branch_taken) begin
            ifid_flush = 1'b1;
            state_next = FLUSH;
          end else begin
            state_next = RUN;
          end
        end
      end
    endcase
  end

  always_comb begin
    id_entry.valid   = id_rf_enable && !nop_sel && !ifid_flush;
    id_entry.rd      = id_rd;
    id_entry.is_load = id_load_instr;
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_reg    <= WARMUP;
      warm_cnt_reg <= '0;
      ex_reg       <= '0;
      mem_reg      <= '0;
      wb_reg       <= '0;
      stall_count  <= '0;
      flush_count  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == WARMUP && warm_cnt_reg != WARM_LAST)
        warm_cnt_reg <= warm_cnt_reg + WW'(1);
      ex_reg  <= id_entry;
      mem_reg <= ex_reg;
      wb_reg  <= mem_reg;
      if (state_reg != WARMUP && lu && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
      if (ifid_flush && flush_count != '1)
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed hazard scenarios plus random instruction streams
// compared every cycle against a history-based reference model.
module tb_pipeline_hazard_ctrl;
  localparam int WC = 2;
  localparam int CW = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic R = 1'b0;
  logic [3:0] id_rn = '0, id_rm = '0, id_rs = '0, id_rd = '0;
  logic id_rn_used = 1'b0, id_rm_used = 1'b0, id_rs_used = 1'b0;
  logic id_rf_enable = 1'b0, id_load_instr = 1'b0, branch_taken = 1'b0;
  logic pc_le, ifid_le, ifid_flush, nop_sel;
  logic [1:0] fwd_a, fwd_b, fwd_c;
  logic [CW-1:0] stall_count, flush_count;

  pipeline_hazard_ctrl #(.WARMUP_CYCLES(WC), .CNT_W(CW)) dut (
    .clk(clk), .R(R),
    .id_rn(id_rn), .id_rm(id_rm), .id_rs(id_rs),
    .id_rn_used(id_rn_used), .id_rm_used(id_rm_used), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_rf_enable(id_rf_enable), .id_load_instr(id_load_instr),
    .branch_taken(branch_taken),
    .pc_le(pc_le), .ifid_le(ifid_le), .ifid_flush(ifid_flush), .nop_sel(nop_sel),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  // Reference model: warm-up cycles left plus the last three ID entries (index 0 = EX).
  bit m_warm;
  int m_wcnt;
  bit hv[3];
  int hr[3];
  bit hl[3];
  int m_sc, m_fc;
  bit e_pc, e_ifid, e_fl, e_nop, e_lu;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s cyc=%0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  task automatic model_reset();
    m_warm = 1'b1;
    m_wcnt = 0;
    for (int k = 0; k < 3; k++) begin hv[k] = 0; hr[k] = 0; hl[k] = 0; end
    m_sc = 0;
    m_fc = 0;
  endtask

  function automatic int model_fwd(input int s, input bit u);
    if (!u || s == 15) return 0;
    for (int k = 0; k < 3; k++) begin
      if (hv[k] && hr[k] == s) begin
        if (k == 0 && hl[0]) continue;
        return k + 1;
      end
    end
    return 0;
  endfunction

  function automatic bit uses_ex(input int s, input bit u);
    return u && s != 15 && hv[0] && hr[0] == s;
  endfunction

  task automatic cmp_all();
    e_lu = hl[0] && (uses_ex(int'(id_rn), id_rn_used) || uses_ex(int'(id_rm), id_rm_used) ||
                     uses_ex(int'(id_rs), id_rs_used));
    if (m_warm || e_lu) begin
      e_pc = 0; e_ifid = 0; e_nop = 1; e_fl = 0;
    end else begin
      e_pc = 1; e_ifid = 1; e_nop = 0; e_fl = branch_taken;
    end
    chk("pc_le", int'(pc_le), int'(e_pc));
    chk("ifid_le", int'(ifid_le), int'(e_ifid));
    chk("ifid_flush", int'(ifid_flush), int'(e_fl));
    chk("nop_sel", int'(nop_sel), int'(e_nop));
    chk("fwd_a", int'(fwd_a), model_fwd(int'(id_rn), id_rn_used));
    chk("fwd_b", int'(fwd_b), model_fwd(int'(id_rm), id_rm_used));
    chk("fwd_c", int'(fwd_c), model_fwd(int'(id_rs), id_rs_used));
    chk("stall_count", int'(stall_count), m_sc);
    chk("flush_count", int'(flush_count), m_fc);
    $display("cyc=%0d R=%0d rn=%0d rm=%0d rs=%0d rd=%0d rf=%0d ld=%0d br=%0d -> pc=%0d nop=%0d fl=%0d fwd=%0d/%0d/%0d sc=%0d fc=%0d",
             cyc, R, id_rn, id_rm, id_rs, id_rd, id_rf_enable, id_load_instr, branch_taken,
             pc_le, nop_sel, ifid_flush, fwd_a, fwd_b, fwd_c, stall_count, flush_count);
  endtask

  task automatic step(input int rn, input int rm, input int rs, input bit un, input bit um,
                      input bit us, input int rd, input bit rf, input bit ld, input bit br);
    id_rn = 4'(rn); id_rm = 4'(rm); id_rs = 4'(rs);
    id_rn_used = un; id_rm_used = um; id_rs_used = us;
    id_rd = 4'(rd); id_rf_enable = rf; id_load_instr = ld; branch_taken = br;
    #1;
    cmp_all();
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (R) begin
      if (m_warm) begin
        if (m_wcnt == WC - 1) m_warm = 0;
        m_wcnt++;
      end else if (e_lu && m_sc < CMAX) begin
        m_sc++;
      end
      if (e_fl && m_fc < CMAX) m_fc++;
      hv[2] = hv[1]; hr[2] = hr[1]; hl[2] = hl[1];
      hv[1] = hv[0]; hr[1] = hr[0]; hl[1] = hl[0];
      hv[0] = id_rf_enable && !e_nop && !e_fl;
      hr[0] = int'(id_rd);
      hl[0] = id_load_instr;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic async_reset();
    R = 1'b0;
    #1;
    model_reset();
    cmp_all();
    tick();
    R = 1'b1;
  endtask

  function automatic int rreg();
    int v;
    v = $urandom_range(0, 4);
    return (v == 4) ? 15 : v;
  endfunction

  initial begin
    model_reset();
    #1;
    cmp_all();
    chk("rst_nop_sel", int'(nop_sel), 1);
    chk("rst_pc_le", int'(pc_le), 0);
    repeat (2) @(negedge clk);
    R = 1'b1;

    // Warm-up: exactly two edges with PC held.
    nop(); chk("warm1_pc", int'(pc_le), 0); tick();
    nop(); chk("warm2_pc", int'(pc_le), 0); tick();
    nop(); chk("warm3_pc", int'(pc_le), 1); tick();

    // ADD r1 followed by SUB r2,r1,r3 at distances 1, 2, 3.
    for (int gap = 0; gap < 3; gap++) begin
      repeat (3) begin nop(); tick(); end
      step(2, 3, 0, 1, 1, 0, 1, 1, 0, 0); tick();
      repeat (gap) begin nop(); tick(); end
      step(1, 3, 0, 1, 1, 0, 2, 1, 0, 0);
      chk("add_sub_fwd_a", int'(fwd_a), gap + 1);
      tick();
    end

    // LDR r4 then ADD r5,r4,r4.
    repeat (3) begin nop(); tick(); end
    step(0, 0, 0, 1, 0, 0, 4, 1, 1, 0); tick();
    step(4, 4, 0, 1, 1, 0, 5, 1, 0, 0);
    chk("lu_pc_le", int'(pc_le), 0);
    chk("lu_nop_sel", int'(nop_sel), 1);
    tick();
    step(4, 4, 0, 1, 1, 0, 5, 1, 0, 0);
    chk("lu_fwd_a", int'(fwd_a), 2);
    chk("lu_fwd_b", int'(fwd_b), 2);
    chk("lu_stall_count", int'(stall_count), 1);
    tick();

    // Taken BL writing r6: flushed, so r6 is never forwarded from it.
    repeat (3) begin nop(); tick(); end
    step(0, 0, 0, 0, 0, 0, 6, 1, 0, 1);
    chk("br_flush", int'(ifid_flush), 1);
    tick();
    step(6, 0, 0, 1, 0, 0, 7, 1, 0, 0);
    chk("br_flush_count", int'(flush_count), 1);
    chk("br_fwd_a", int'(fwd_a), 0);
    tick();

    // LDR r2 then a taken branch reading r2: stall first, flush next cycle.
    repeat (3) begin nop(); tick(); end
    step(0, 0, 0, 0, 0, 0, 2, 1, 1, 0); tick();
    step(2, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    chk("ldbr_flush0", int'(ifid_flush), 0);
    chk("ldbr_pc0", int'(pc_le), 0);
    tick();
    step(2, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    chk("ldbr_flush1", int'(ifid_flush), 1);
    chk("ldbr_fwd_a", int'(fwd_a), 2);
    tick();

    // r15 never forwards and never stalls, even behind a load of r15.
    repeat (3) begin nop(); tick(); end
    step(0, 0, 0, 0, 0, 0, 15, 1, 1, 0); tick();
    step(15, 15, 15, 1, 1, 1, 3, 1, 0, 0);
    chk("r15_fwd_a", int'(fwd_a), 0);
    chk("r15_pc_le", int'(pc_le), 1);
    tick();

    // Reset asserted mid-stall.
    repeat (3) begin nop(); tick(); end
    step(0, 0, 0, 0, 0, 0, 3, 1, 1, 0); tick();
    step(3, 0, 0, 1, 0, 0, 4, 1, 0, 0);
    chk("rst_stall_pc", int'(pc_le), 0);
    R = 1'b0;
    #1;
    chk("async_rst_nop", int'(nop_sel), 1);
    chk("async_rst_ifid", int'(ifid_le), 0);
    chk("async_rst_fwd_a", int'(fwd_a), 0);
    chk("async_rst_sc", int'(stall_count), 0);
    model_reset();
    tick();
    R = 1'b1;

    // Random instruction stream with occasional asynchronous resets.
    for (int n = 0; n < 2000; n++) begin
      step(rreg(), rreg(), rreg(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), rreg(), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 199) == 0) async_reset();
      else tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
